jimmy_run_controller: RTL and testbench
=======================================

// Module: jimmy_run_controller
// PURPOSE
//  Sequences one benchmark run of the jimmy soft CPU on the Basys3 board.
//  A start press resets the CPU and presents the program start address. The block then
//  releases the CPU, counts clocks until the CPU completion flag rises, and latches the
//  result strobed out by the CPU. Result and cycle count feed the display/LED mux.
// PARAMETERS
//  RST_CYCLES      4           clocks cpu_rst_n is held low before release (>=1)
//  TIMEOUT_CYCLES  32'd50_000_000  RUN watchdog limit (used only with JIMMY_TIMEOUT_EN)
// PORTS
//  clk             in   1   system clock, 100 MHz
//  reset           in   1   reset, synchronous, active-low
//  start_btn       in   1   raw start button, asynchronous, active-high
//  start_addr      in   8   program start address, sampled on run start
//  cpu_done        in   1   CPU completion flag (complete_bus[0]), clk domain
//  cpu_strobe      in   1   CPU result strobe (out_strobe[3]), clk domain
//  cpu_result      in   8   CPU result port (out_port_3)
//  cpu_rst_n       out  1   CPU reset, active-low
//  cpu_start_addr  out  8   start address driven to the CPU in_port_1
//  result          out  8   latched run result
//  cycles          out  32  clocks spent in RUN, saturating
//  busy            out  1   high in RST_CPU and RUN
//  done            out  1   high in DONE
//  timeout         out  1   watchdog fired (constant 0 without JIMMY_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state=IDLE, cpu_rst_n=0, cpu_start_addr=0,
//    result=0, cycles=0, busy=0, done=0, timeout=0, synchronizer and edge registers=0.
//  - start_btn passes through a 2-FF synchronizer. start_pulse = sync2 & ~sync3 (one clock).
//    The first FSM reaction comes 3 clocks after start_btn is seen high.
//  - cpu_strobe is registered once. strobe_fall = strb_q & ~cpu_strobe.
//  - FSM states:
//    IDLE    cpu_rst_n=0. On start_pulse: cpu_start_addr<=start_addr, cycles<=0, result<=0,
//            timeout<=0, rst_cnt<=0, go to RST_CPU.
//    RST_CPU cpu_rst_n=0, rst_cnt++. When rst_cnt==RST_CYCLES-1, go to RUN.
//            cpu_rst_n goes 1 on that same edge.
//    RUN     cpu_rst_n=1. cycles+1 each clock, saturating at 32'hFFFF_FFFF.
//            On strobe_fall: result<=cpu_result.
//            On cpu_done==1: go to DONE. cycles is not incremented on that clock.
//            strobe_fall and cpu_done in the same clock: result captured, then DONE.
//    DONE    cpu_rst_n stays 1 (CPU is parked). result and cycles are frozen.
//            On start_pulse: same actions as from IDLE (a new run starts).
//  - start_pulse in RST_CPU or RUN is ignored.
//  - Reset mid-run: state returns to IDLE, all outputs take reset values, and the CPU
//    is held in reset on the next clock.
//  - cycles equals the number of clocks with cpu_rst_n=1 and cpu_done=0.
//    This matches the gated cycle count already used on the board.
// CONFIGURATION
//  JIMMY_TIMEOUT_EN defined:
//    In RUN, when cycles==TIMEOUT_CYCLES-1 and cpu_done==0: timeout<=1, go to DONE.
//    result keeps its last captured value.
//  JIMMY_TIMEOUT_EN undefined:
//    No watchdog logic. timeout tied 0. RUN waits forever for cpu_done.
// STRUCTURE
//  - jimmy_ctrl_pkg: state localparams (IDLE=2'd0, RST_CPU=2'd1, RUN=2'd2, DONE=2'd3),
//    CYCLES_MAX constant, ADDR_W=8 and DATA_W=8 widths.
//  - One sub-module, sync_edge_detect: 2-FF synchronizer plus rising-edge pulse,
//    used for start_btn.
//  - FSM, rst_cnt, cycle counter and result register stay in this module.
// TESTING
//  1. reset=0 for 3 clocks, then 1 with no start -> all outputs 0, state IDLE,
//     cpu_rst_n=0 indefinitely.
//  2. start_addr=8'h10, start_btn pulse; cpu_strobe 1->0 with cpu_result=8'd7 after
//     20 run clocks; cpu_done=1 at run clock 100 -> cpu_start_addr=8'h10,
//     cpu_rst_n low 4 clocks, result=7, cycles=100, done=1, busy=0.
//  3. In RUN, strobe_fall with cpu_result=8'd3 and cpu_done=1 in the same clock
//     -> result=3, DONE reached, cycles not incremented on that clock.
//  4. start_btn pulsed again mid-RUN -> ignored, cycles keeps counting;
//     pulse in DONE -> result=0, cycles=0, new run starts.
//  5. reset=0 asserted mid-RUN (cycles=50) -> next clock: IDLE, cycles=0, result=0,
//     cpu_rst_n=0.
//  6. JIMMY_TIMEOUT_EN with TIMEOUT_CYCLES=32'd64, cpu_done held 0 -> timeout=1,
//     done=1, cycles=64.

Source files
------------

// File: rtl/jimmy_ctrl_pkg.sv
// Shared types and widths for the jimmy benchmark run controller.
package jimmy_ctrl_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RST_CPU = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } run_state_e;

endpackage

// File: rtl/jimmy_run_controller_sync_edge_detect.sv
// 2-FF synchronizer for an asynchronous level, followed by a one-clock rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n_i,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/jimmy_run_controller.sv
// Sequences one benchmark run of the jimmy soft CPU: reset, run, capture result and cycle count.
// Optional RUN watchdog enabled by defining JIMMY_TIMEOUT_EN.
module jimmy_run_controller
  import jimmy_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              cpu_done,
  input  logic              cpu_strobe,
  input  logic [DATA_W-1:0] cpu_result,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] cpu_start_addr,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              strb_q;
  logic              start_pulse;
  logic              strobe_fall;

`ifdef JIMMY_TIMEOUT_EN
  logic              timeout_q, timeout_d;
`endif

  sync_edge_detect u_start_sync (
    .clk       (clk),
    .reset_n_i (reset),
    .async_i   (start_btn),
    .pulse_o   (start_pulse)
  );

  assign strobe_fall = strb_q & ~cpu_strobe;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycles_d  = cycles_q;
    result_d  = result_q;
    addr_d    = addr_q;
`ifdef JIMMY_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_pulse) begin
          addr_d    = start_addr;
          cycles_d  = '0;
          result_d  = '0;
          rst_cnt_d = '0;
`ifdef JIMMY_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = RST_CPU;
        end
      end
      RST_CPU: begin
        rst_cnt_d = rst_cnt_q + RST_W'(1);
        if (rst_cnt_q == RST_LAST) state_d = RUN;
      end
      RUN: begin
        if (strobe_fall) result_d = cpu_result;
        if (cpu_done) begin
          state_d = DONE;
        end else begin
          if (cycles_q != CYCLES_MAX) cycles_d = cycles_q + 32'd1;
`ifdef JIMMY_TIMEOUT_EN
          // The firing clock still counts, so cycles lands exactly on TIMEOUT_CYCLES.
          if (cycles_q == TIMEOUT_CYCLES - 32'd1) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // CPU is released on the RST_CPU->RUN edge and stays released while parked in DONE.
    cpu_rst_n_d = (state_d == RUN) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      cycles_q    <= '0;
      result_q    <= '0;
      addr_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      strb_q      <= 1'b0;
`ifdef JIMMY_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      strb_q      <= cpu_strobe;
`ifdef JIMMY_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign cpu_rst_n      = cpu_rst_n_q;
  assign cpu_start_addr = addr_q;
  assign result         = result_q;
  assign cycles         = cycles_q;
  assign busy           = (state_q == RST_CPU) || (state_q == RUN);
  assign done           = (state_q == DONE);
`ifdef JIMMY_TIMEOUT_EN
  assign timeout        = timeout_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_jimmy_run_controller.sv
// Directed self-checking bench for jimmy_run_controller; timeout scenario runs when JIMMY_TIMEOUT_EN is defined.
module tb_jimmy_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic [7:0]  start_addr;
  logic        cpu_done;
  logic        cpu_strobe;
  logic [7:0]  cpu_result;
  logic        cpu_rst_n;
  logic [7:0]  cpu_start_addr;
  logic [7:0]  result;
  logic [31:0] cycles;
  logic        busy;
  logic        done;
  logic        timeout;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

`ifdef JIMMY_TIMEOUT_EN
  jimmy_run_controller #(.RST_CYCLES(4), .TIMEOUT_CYCLES(32'd64)) dut (
`else
  jimmy_run_controller #(.RST_CYCLES(4)) dut (
`endif
    .clk            (clk),
    .reset          (reset),
    .start_btn      (start_btn),
    .start_addr     (start_addr),
    .cpu_done       (cpu_done),
    .cpu_strobe     (cpu_strobe),
    .cpu_result     (cpu_result),
    .cpu_rst_n      (cpu_rst_n),
    .cpu_start_addr (cpu_start_addr),
    .result         (result),
    .cycles         (cycles),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-clock button press; returns after the FSM has entered RST_CPU.
  task automatic press_start(input logic [7:0] addr);
    start_addr = addr;
    start_btn  = 1'b1;
    tick();
    start_btn  = 1'b0;
    tick();
    tick();
  endtask

  // Counts clocks until the CPU is released (bounded).
  task automatic wait_release(output int n);
    n = 0;
    while (!cpu_rst_n && n < 20) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    reset = 1'b0; start_btn = 1'b0; start_addr = '0;
    cpu_done = 1'b0; cpu_strobe = 1'b0; cpu_result = '0;

    // 1: reset, then idle with no start
    repeat (3) tick();
    reset = 1'b1;
    repeat (6) tick();
    check_eq("idle_rst_n",  cpu_rst_n,      0);
    check_eq("idle_busy",   busy,           0);
    check_eq("idle_done",   done,           0);
    check_eq("idle_result", result,         0);
    check_eq("idle_cycles", cycles,         0);
    check_eq("idle_addr",   cpu_start_addr, 0);
    check_eq("idle_tmo",    timeout,        0);

    // 2: full run, strobe after 20 run clocks, done at run clock 100
    start_addr = 8'h10;
    start_btn  = 1'b1;
    tick();
    start_btn  = 1'b0;
    tick();
    check_eq("no_early_busy", busy, 0);
    tick();
    check_eq("r2_busy",  busy,           1);
    check_eq("r2_addr",  cpu_start_addr, 8'h10);
    wait_release(n);
    check_eq("r2_rst_len", n, 4);
    check_eq("r2_cyc0",    cycles, 0);
    for (int i = 0; i < 100; i++) begin
      cpu_strobe = (i == 19);
      cpu_result = 8'd7;
      tick();
    end
    cpu_strobe = 1'b0;
    check_eq("r2_run_cyc",  cycles,  100);
    check_eq("r2_run_done", done,    0);
    check_eq("r2_no_tmo",   timeout, 0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check_eq("r2_done",   done,      1);
    check_eq("r2_busy0",  busy,      0);
    check_eq("r2_result", result,    7);
    check_eq("r2_cycles", cycles,    100);
    check_eq("r2_parked", cpu_rst_n, 1);
    repeat (3) tick();
    check_eq("r2_frozen", cycles, 100);

    // 4b: press in DONE restarts; 4a: press mid-RUN ignored; 3: strobe_fall with done
    press_start(8'h22);
    check_eq("r4_result0", result,         0);
    check_eq("r4_cycles0", cycles,         0);
    check_eq("r4_busy",    busy,           1);
    check_eq("r4_addr",    cpu_start_addr, 8'h22);
    check_eq("r4_rst_n",   cpu_rst_n,      0);
    wait_release(n);
    check_eq("r4_rst_len", n, 4);
    for (int i = 0; i < 30; i++) begin
      start_btn = (i == 10);
      tick();
    end
    start_btn = 1'b0;
    check_eq("r4_ignored_cyc",  cycles, 30);
    check_eq("r4_ignored_busy", busy,   1);
    cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0;
    cpu_result = 8'd3;
    cpu_done   = 1'b1;
    tick();
    cpu_done = 1'b0;
    check_eq("r3_result", result, 3);
    check_eq("r3_done",   done,   1);
    check_eq("r3_cycles", cycles, 31);

    // 5: reset mid-run at cycles=50
    press_start(8'h55);
    wait_release(n);
    repeat (50) tick();
    check_eq("r5_cyc50", cycles, 50);
    reset = 1'b0;
    tick();
    check_eq("r5_cycles", cycles,         0);
    check_eq("r5_result", result,         0);
    check_eq("r5_rst_n",  cpu_rst_n,      0);
    check_eq("r5_busy",   busy,           0);
    check_eq("r5_done",   done,           0);
    check_eq("r5_addr",   cpu_start_addr, 0);
    reset = 1'b1;
    repeat (4) tick();
    check_eq("r5_idle_busy",  busy,      0);
    check_eq("r5_idle_rst_n", cpu_rst_n, 0);

`ifdef JIMMY_TIMEOUT_EN
    // 6: watchdog at 64 clocks with cpu_done held low
    press_start(8'h01);
    wait_release(n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check_eq("r6_tmo_clks", n,       64);
    check_eq("r6_timeout",  timeout, 1);
    check_eq("r6_done",     done,    1);
    check_eq("r6_cycles",   cycles,  64);
    check_eq("r6_result",   result,  0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
